if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 127 ++++++++++++
 tb/tb_if_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, single-entry hold buffer for a stall that
// arrives together with an accepted fetch, and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        _stall_en,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic [15:0] stall_cycles
);

    typedef enum logic [0:0] {StFetch, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic        accept;

    assign accept = (state_q == StFetch) && imem_ready;

    // Next-state logic: flush beats stall, stall beats normal advance.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_pc_d      = hold_pc_q;
        hold_inst_d    = hold_inst_q;
        if_id_pc_d     = if_id_pc_q;
        if_id_pc4_d    = if_id_pc4_q;
        if_id_inst_d   = if_id_inst_q;
        if_id_valid_d  = if_id_valid_q;
        stall_cycles_d = stall_cycles_q;

        if (!_stall_en && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end

        if (flush) begin
            // Masking keeps the PC word aligned; any fetched or held word is dropped.
            pc_d          = redirect_pc & 32'hFFFF_FFFC;
            if_id_valid_d = 1'b0;
            if_id_inst_d  = NOP_INST;
            state_d       = StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (accept) begin
                        pc_d = pc_q + 32'd4;
                        if (_stall_en) begin
                            if_id_pc_d    = pc_q;
                            if_id_pc4_d   = pc_q + 32'd4;
                            if_id_inst_d  = imem_rdata;
                            if_id_valid_d = 1'b1;
                        end else begin
                            // Decode is frozen, so park the word until it can move on.
                            hold_pc_d   = pc_q;
                            hold_inst_d = imem_rdata;
                            state_d     = StHold;
                        end
                    end else if (_stall_en) begin
                        if_id_valid_d = 1'b0;
                        if_id_inst_d  = NOP_INST;
                    end
                end
                StHold: begin
                    if (_stall_en) begin
                        if_id_pc_d    = hold_pc_q;
                        if_id_pc4_d   = hold_pc_q + 32'd4;
                        if_id_inst_d  = hold_inst_q;
                        if_id_valid_d = 1'b1;
                        state_d       = StFetch;
                    end
                end
            endcase
        end
    end

    // State registers with synchronous reset that overrides every other rule.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StFetch;
            pc_q           <= RESET_PC;
            hold_pc_q      <= 32'h0;
            hold_inst_q    <= 32'h0;
            if_id_pc_q     <= 32'h0;
            if_id_pc4_q    <= 32'h4;
            if_id_inst_q   <= NOP_INST;
            if_id_valid_q  <= 1'b0;
            stall_cycles_q <= 16'h0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            hold_pc_q      <= hold_pc_d;
            hold_inst_q    <= hold_inst_d;
            if_id_pc_q     <= if_id_pc_d;
            if_id_pc4_q    <= if_id_pc4_d;
            if_id_inst_q   <= if_id_inst_d;
            if_id_valid_q  <= if_id_valid_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign imem_req     = (state_q == StFetch);
    assign imem_addr    = pc_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_pc4    = if_id_pc4_q;
    assign if_id_inst   = if_id_inst_q;
    assign if_id_valid  = if_id_valid_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed per-cycle vector table, a randomised scoreboard run,
// and a long stall sequence for counter saturation.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_en;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        ._stall_en    (stall_en),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_inst   (if_id_inst),
        .if_id_valid  (if_id_valid),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall_en;
        logic        flush;
        logic [31:0] redir;
        logic        ready;
        logic [31:0] rdata;
        logic        chk_pre;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_inst;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    vec_t tv[$];
    sb_t  sb[$];

    localparam logic [31:0] WA = 32'hA0A0_0001;
    localparam logic [31:0] WB = 32'hB0B0_0002;
    localparam logic [31:0] WC = 32'hC0C0_0003;
    localparam logic [31:0] WD = 32'hD0D0_0004;
    localparam logic [31:0] WE = 32'hE0E0_0005;
    localparam logic [31:0] WF = 32'hF0F0_0006;
    localparam logic [31:0] WG = 32'h1111_0007;
    localparam logic [31:0] WH = 32'h2222_0008;
    localparam logic [31:0] WI = 32'h3333_0009;
    localparam logic [31:0] WJ = 32'h4444_000A;
    localparam logic [31:0] WK = 32'h5555_000B;
    localparam logic [31:0] WL = 32'h6666_000C;
    localparam logic [31:0] WM = 32'h7777_000D;

    function automatic vec_t mk(
        input string n, input logic r, input logic s, input logic f, input logic [31:0] rd,
        input logic rdy, input logic [31:0] dat, input logic cp, input logic eq,
        input logic [31:0] ea, input logic ev, input logic [31:0] ep, input logic [31:0] ep4,
        input logic [31:0] ei, input logic [15:0] ec);
        vec_t v;
        v.name = n; v.rst = r; v.stall_en = s; v.flush = f; v.redir = rd;
        v.ready = rdy; v.rdata = dat; v.chk_pre = cp; v.e_req = eq; v.e_addr = ea;
        v.e_valid = ev; v.e_pc = ep; v.e_pc4 = ep4; v.e_inst = ei; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        rst = v.rst; stall_en = v.stall_en; flush = v.flush; redirect_pc = v.redir;
        imem_ready = v.ready; imem_rdata = v.rdata;
        #1;
        if (v.chk_pre) begin
            chk({v.name, ".imem_req"}, {31'b0, imem_req}, {31'b0, v.e_req});
            chk({v.name, ".imem_addr"}, imem_addr, v.e_addr);
        end
        @(posedge clk);
        #1;
        chk({v.name, ".valid"}, {31'b0, if_id_valid}, {31'b0, v.e_valid});
        chk({v.name, ".pc"}, if_id_pc, v.e_pc);
        chk({v.name, ".pc4"}, if_id_pc4, v.e_pc4);
        chk({v.name, ".inst"}, if_id_inst, v.e_inst);
        chk({v.name, ".stall_cycles"}, {16'b0, stall_cycles}, {16'b0, v.e_cnt});
    endtask

    initial begin
        logic [31:0] m_pc;
        logic [15:0] m_cnt;
        logic        acc;
        sb_t         e;

        rst = 1'b1; stall_en = 1'b1; flush = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0; imem_rdata = 32'h0;

        //      name            rst st fl redir          rdy rdata  cp req addr           v  pc             pc4            inst cnt
        tv.push_back(mk("rst0",        1, 1, 0, 32'h0,        0, 32'h0, 0, 0, 32'h0,        0, 32'h0,        32'h4,         32'h0, 0));
        tv.push_back(mk("rst1",        1, 1, 0, 32'h0,        0, 32'h0, 1, 1, 32'h0,        0, 32'h0,        32'h4,         32'h0, 0));
        tv.push_back(mk("seq_a",       0, 1, 0, 32'h0,        1, WA,    1, 1, 32'h0,        1, 32'h0,        32'h4,         WA,    0));
        tv.push_back(mk("seq_b",       0, 1, 0, 32'h0,        1, WB,    1, 1, 32'h4,        1, 32'h4,        32'h8,         WB,    0));
        tv.push_back(mk("seq_c",       0, 1, 0, 32'h0,        1, WC,    1, 1, 32'h8,        1, 32'h8,        32'hC,         WC,    0));
        tv.push_back(mk("seq_d",       0, 1, 0, 32'h0,        1, WD,    1, 1, 32'hC,        1, 32'hC,        32'h10,        WD,    0));
        tv.push_back(mk("stl_acc",     0, 0, 0, 32'h0,        1, WE,    1, 1, 32'h10,       1, 32'hC,        32'h10,        WD,    1));
        tv.push_back(mk("stl_hold",    0, 0, 0, 32'h0,        1, 32'hDEADBEEF, 1, 0, 32'h14, 1, 32'hC,       32'h10,        WD,    2));
        tv.push_back(mk("stl_rel",     0, 1, 0, 32'h0,        0, 32'h0, 1, 0, 32'h14,       1, 32'h10,       32'h14,        WE,    2));
        tv.push_back(mk("wait0",       0, 1, 0, 32'h0,        0, 32'h12345678, 1, 1, 32'h14, 0, 32'h10,      32'h14,        32'h0, 2));
        tv.push_back(mk("wait1",       0, 1, 0, 32'h0,        0, 32'h12345678, 1, 1, 32'h14, 0, 32'h10,      32'h14,        32'h0, 2));
        tv.push_back(mk("wait2",       0, 1, 0, 32'h0,        0, 32'h12345678, 1, 1, 32'h14, 0, 32'h10,      32'h14,        32'h0, 2));
        tv.push_back(mk("wait_done",   0, 1, 0, 32'h0,        1, WF,    1, 1, 32'h14,       1, 32'h14,       32'h18,        WF,    2));
        tv.push_back(mk("hold_cap",    0, 0, 0, 32'h0,        1, WG,    1, 1, 32'h18,       1, 32'h14,       32'h18,        WF,    3));
        tv.push_back(mk("hold_flush",  0, 0, 1, 32'h107,      0, 32'h0, 1, 0, 32'h1C,       0, 32'h14,       32'h18,        32'h0, 4));
        tv.push_back(mk("post_flush",  0, 1, 0, 32'h0,        1, WH,    1, 1, 32'h104,      1, 32'h104,      32'h108,       WH,    4));
        tv.push_back(mk("fetch_flush", 0, 1, 1, 32'h200,      1, WI,    1, 1, 32'h108,      0, 32'h104,      32'h108,       32'h0, 4));
        tv.push_back(mk("redir_tgt",   0, 1, 0, 32'h0,        1, WJ,    1, 1, 32'h200,      1, 32'h200,      32'h204,       WJ,    4));
        tv.push_back(mk("pre_rst_cap", 0, 0, 0, 32'h0,        1, WK,    1, 1, 32'h204,      1, 32'h200,      32'h204,       WJ,    5));
        tv.push_back(mk("rst_in_hold", 1, 1, 0, 32'h0,        1, 32'h0, 1, 0, 32'h208,      0, 32'h0,        32'h4,         32'h0, 0));
        tv.push_back(mk("rst_no_emit", 0, 1, 0, 32'h0,        0, 32'h0, 1, 1, 32'h0,        0, 32'h0,        32'h4,         32'h0, 0));
        tv.push_back(mk("rst_fetch",   0, 1, 0, 32'h0,        1, WL,    1, 1, 32'h0,        1, 32'h0,        32'h4,         WL,    0));
        tv.push_back(mk("wrap_redir",  0, 0, 1, 32'hFFFFFFFC, 0, 32'h0, 1, 1, 32'h4,        0, 32'h0,        32'h4,         32'h0, 1));
        tv.push_back(mk("wrap_acc",    0, 1, 0, 32'h0,        1, WM,    1, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h0,         WM,    1));
        tv.push_back(mk("wrap_next",   0, 1, 0, 32'h0,        0, 32'h0, 1, 1, 32'h0,        0, 32'hFFFFFFFC, 32'h0,         32'h0, 1));

        foreach (tv[i]) apply_vec(tv[i]);

        // Randomised run against a fetch-order scoreboard.
        @(negedge clk);
        rst = 1'b1; stall_en = 1'b1; flush = 1'b0; imem_ready = 1'b0;
        @(posedge clk);
        #1;
        m_pc = 32'h0;
        m_cnt = 16'h0;
        sb.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst = 1'b0;
            stall_en = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                      : $urandom();
            imem_ready = $urandom_range(0, 1) == 1;
            imem_rdata = $urandom();
            #1;
            chk("rnd.imem_req", {31'b0, imem_req}, {31'b0, sb.size() == 0});
            chk("rnd.imem_addr", imem_addr, m_pc);
            acc = (sb.size() == 0) && imem_ready;
            if (flush) begin
                sb.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (acc) begin
                e.pc = m_pc;
                e.inst = imem_rdata;
                sb.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            if (!stall_en && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            @(posedge clk);
            #1;
            if (flush) begin
                chk("rnd.flush_valid", {31'b0, if_id_valid}, 32'h0);
                chk("rnd.flush_inst", if_id_inst, 32'h0);
            end else if (stall_en) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rnd.valid", {31'b0, if_id_valid}, 32'h1);
                    chk("rnd.pc", if_id_pc, e.pc);
                    chk("rnd.pc4", if_id_pc4, e.pc + 32'd4);
                    chk("rnd.inst", if_id_inst, e.inst);
                end else begin
                    chk("rnd.bubble_valid", {31'b0, if_id_valid}, 32'h0);
                    chk("rnd.bubble_inst", if_id_inst, 32'h0);
                end
            end
            chk("rnd.stall_cycles", {16'b0, stall_cycles}, {16'b0, m_cnt});
        end

        // Counter saturation: reset wins over a stall, then 70000 stall cycles.
        @(negedge clk);
        rst = 1'b1; stall_en = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("sat.reset", {16'b0, stall_cycles}, 32'h0);
        rst = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat.fffe", {16'b0, stall_cycles}, 32'hFFFE);
        @(posedge clk);
        #1;
        chk("sat.ffff", {16'b0, stall_cycles}, 32'hFFFF);
        repeat (70000 - 65535) @(posedge clk);
        #1;
        chk("sat.hold", {16'b0, stall_cycles}, 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
